// File: rtl/flit_injector.sv
// flit_injector: turns a packet descriptor plus a stream of payload words into
// a HEADER / BODY... / TAIL flit sequence on one mesh edge port.
// Optional statistics counters are built when FLIT_INJECTOR_STATS_EN is defined.
//
// Handshakes: desc_valid/desc_ready, pl_valid/pl_ready and out_enable/out_ack
// each transfer on a rising edge where both sides are high. A ready never
// depends on its own valid, and once out_enable rises out_flit is held
// bit-stable until the transfer edge.

package flit_injector_pkg;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } addr_t;

    typedef enum logic [1:0] {
        FLIT_NONE = 2'd0,
        HEADER    = 2'd1,
        BODY      = 2'd2,
        TAIL      = 2'd3
    } flit_kind_t;

    // Header payload layout inside the flit data field.
    typedef struct packed {
        logic [1:0] rsvd;
        addr_t      dst_addr;
        logic [7:0] tail_length;
    } hdr_t;

    typedef struct packed {
        flit_kind_t        kind;
        logic [DATA_W-1:0] data;
    } flit_t;
endpackage

module flit_injector
    import flit_injector_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  addr_t             desc_dst,
    input  logic [LEN_W-1:0]  desc_len,
    output logic              desc_err,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    output logic              out_enable,
    output flit_t             out_flit,
    input  logic              out_ack,
    output logic [1:0]        dbg_state
`ifdef FLIT_INJECTOR_STATS_EN
    ,
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_flits,
    output logic [31:0]       stat_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_HDR = 2'd1,
        PAYLOAD  = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    hdr_t             hdr_word;
    logic             xfer;
    logic             desc_fire;
    logic             pl_fire;
    logic             len_ok;
    logic             last_word;

    assign xfer      = out_enable && out_ack;
    assign desc_fire = desc_valid && desc_ready;
    assign pl_fire   = pl_valid && pl_ready;
    assign len_ok    = (desc_len != '0) && (desc_len <= LEN_W'(MAX_LEN));
    assign last_word = (remaining == LEN_W'(1));
    assign dbg_state = state;

    // Ready generation: the first payload word may ride on the header transfer
    // so a packet streams with no gap after its header.
    always_comb begin
        desc_ready = (state == IDLE);
        pl_ready   = 1'b0;
        case (state)
            SEND_HDR: pl_ready = out_ack;
            PAYLOAD:  pl_ready = (!out_enable || out_ack) && (remaining != '0);
            default:  pl_ready = 1'b0;
        endcase
    end

    // Header word assembled straight from the descriptor being accepted.
    always_comb begin
        hdr_word             = '0;
        hdr_word.dst_addr    = desc_dst;
        hdr_word.tail_length = 8'(desc_len);
    end

    // Packet FSM with the single-entry output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            out_enable <= 1'b0;
            out_flit   <= '0;
            desc_err   <= 1'b0;
        end else begin
            desc_err <= 1'b0;
            if (xfer) begin
                out_enable <= 1'b0;
            end
            if (pl_fire) begin
                out_enable    <= 1'b1;
                out_flit.kind <= last_word ? TAIL : BODY;
                out_flit.data <= pl_data;
                remaining     <= remaining - LEN_W'(1);
            end
            case (state)
                IDLE: begin
                    if (desc_fire) begin
                        if (len_ok) begin
                            out_enable    <= 1'b1;
                            out_flit.kind <= HEADER;
                            out_flit.data <= hdr_word;
                            remaining     <= desc_len;
                            state         <= SEND_HDR;
                        end else begin
                            desc_err <= 1'b1;
                        end
                    end
                end
                SEND_HDR: begin
                    if (xfer) begin
                        state <= (pl_fire && last_word) ? DRAIN : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pl_fire && last_word) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FLIT_INJECTOR_STATS_EN
    // Traffic counters: packets, flits and stalled cycles, wrapping mod 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts  <= '0;
            stat_flits <= '0;
            stat_stall <= '0;
        end else begin
            if (xfer) begin
                stat_flits <= stat_flits + 32'd1;
            end
            if (xfer && out_flit.kind == TAIL) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (out_enable && !out_ack) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: directed timing checks plus randomized packets
// checked against an expected-flit queue built from the packet format.
module tb_flit_injector;
    import flit_injector_pkg::*;

    localparam int MAX_LEN = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              desc_valid;
    logic              desc_ready;
    addr_t             desc_dst;
    logic [3:0]        desc_len;
    logic              desc_err;
    logic              pl_valid;
    logic              pl_ready;
    logic [DATA_W-1:0] pl_data;
    logic              out_enable;
    flit_t             out_flit;
    logic              out_ack;
    logic [1:0]        dbg_state;
`ifdef FLIT_INJECTOR_STATS_EN
    logic [31:0]       stat_pkts;
    logic [31:0]       stat_flits;
    logic [31:0]       stat_stall;
`endif

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          acc_cnt = 0;
    int          n_xfer  = 0;
    int          n_stall = 0;
    logic [17:0] exp_q[$];
    logic [15:0] pkt_words[8];
    int          pkt_gaps[8];
    logic        ack_rand  = 1'b0;
    logic        ack_level = 1'b1;
    logic        rnd_ack   = 1'b1;

    assign out_ack = ack_rand ? rnd_ack : ack_level;

    flit_injector #(.MAX_LEN(MAX_LEN), .LEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_dst   (desc_dst),
        .desc_len   (desc_len),
        .desc_err   (desc_err),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .pl_data    (pl_data),
        .out_enable (out_enable),
        .out_flit   (out_flit),
        .out_ack    (out_ack),
        .dbg_state  (dbg_state)
`ifdef FLIT_INJECTOR_STATS_EN
        ,
        .stat_pkts  (stat_pkts),
        .stat_flits (stat_flits),
        .stat_stall (stat_stall)
`endif
    );

    // Clock and random acknowledge source.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ack = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] exp_hdr(input logic [5:0] dst, input int len);
        return {2'b01, 2'b00, dst, 8'(len)};
    endfunction

    // Scoreboard / monitor: every transfer must match the queue head, stalled
    // flits must stay put, and the two readies are never high together.
    logic [31:0] mon_exp;
    logic        stall_prev = 1'b0;
    flit_t       flit_prev;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            check("ready_excl", 32'(desc_ready && pl_ready), 0);
            if (stall_prev) begin
                check("stall_en", 32'(out_enable), 1);
                check("stall_flit", 32'(out_flit), 32'(flit_prev));
            end
            if (out_enable && out_ack) begin
                mon_exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
                check("flit", 32'(out_flit), mon_exp);
                n_xfer++;
            end
            if (out_enable && !out_ack) n_stall++;
            stall_prev = out_enable && !out_ack;
            flit_prev  = out_flit;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        desc_valid = 1'b0;
        pl_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_expected(input logic [5:0] dst, input int len);
        exp_q.push_back(exp_hdr(dst, len));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1) ? 2'b11 : 2'b10, pkt_words[i]});
        end
    endtask

    task automatic rand_words(input int gap_max);
        for (int i = 0; i < 8; i++) begin
            pkt_words[i] = 16'($urandom);
            pkt_gaps[i]  = $urandom_range(0, gap_max);
        end
    endtask

    task automatic send_desc(input logic [5:0] dst, input int len);
        logic got;
        desc_valid = 1'b1;
        desc_dst   = dst;
        desc_len   = 4'(len);
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = desc_ready;
        end
        check("desc_accept", 32'(got), 1);
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
        acc_cnt++;
        @(negedge clk);
        check("desc_err", 32'(desc_err), 32'(len < 1 || len > MAX_LEN));
    endtask

    task automatic send_payload(input int len);
        logic got;
        for (int i = 0; i < len; i++) begin
            if (pkt_gaps[i] > 0) begin
                pl_valid = 1'b0;
                repeat (pkt_gaps[i]) begin
                    @(posedge clk);
                    #1;
                end
            end
            pl_valid = 1'b1;
            pl_data  = pkt_words[i];
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                got = pl_ready;
            end
            check("pl_accept", 32'(got), 1);
            @(posedge clk);
            #1;
        end
        pl_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = (exp_q.size() == 0) && desc_ready && !out_enable;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && desc_ready && !out_enable;
        end
        check("idle", 32'(done), 1);
    endtask

    task automatic run_pkt(input logic [5:0] dst, input int len);
        logic legal;
        legal = (len >= 1) && (len <= MAX_LEN);
        if (legal) push_expected(dst, len);
        fork
            send_desc(dst, len);
            if (legal) send_payload(len);
        join
        wait_idle();
        @(posedge clk);
        #1;
    endtask

    // Directed steps followed by a randomized run.
    initial begin
        int k;
        int x0;
        int s0;
        int pat[7];
        logic [5:0] dst;
        int len;

        rst = 1'b1;
        desc_valid = 1'b0;
        desc_dst = '0;
        desc_len = '0;
        pl_valid = 1'b0;
        pl_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_desc_ready", 32'(desc_ready), 1);
        check("rst_desc_err", 32'(desc_err), 0);
        check("rst_pl_ready", 32'(pl_ready), 0);
        check("rst_out_enable", 32'(out_enable), 0);
        check("rst_out_flit", 32'(out_flit), 0);
        check("rst_state", 32'(dbg_state), 0);
`ifdef FLIT_INJECTOR_STATS_EN
        check("rst_stat_pkts", stat_pkts, 0);
        check("rst_stat_flits", stat_flits, 0);
        check("rst_stat_stall", stat_stall, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic packet: dst {1,6}, one word 0xA5.
        rand_words(0);
        pkt_words[0] = 16'h00A5;
        k = acc_cnt + 1;
        fork
            run_pkt({3'd1, 3'd6}, 1);
            begin
                wait (acc_cnt == k);
                @(negedge clk);
                check("basic_hdr_en", 32'(out_enable), 1);
                check("basic_hdr", 32'(out_flit), 32'(exp_hdr({3'd1, 3'd6}, 1)));
                @(negedge clk);
                check("basic_tail_en", 32'(out_enable), 1);
                check("basic_tail", 32'(out_flit), 32'({2'b11, 16'h00A5}));
                @(negedge clk);
                check("basic_rdy", 32'(desc_ready), 1);
                check("basic_idle_en", 32'(out_enable), 0);
            end
        join

        // Full length: payload 1..8 on nine back-to-back cycles.
        rand_words(0);
        for (int i = 0; i < 8; i++) pkt_words[i] = 16'(i + 1);
        k = acc_cnt + 1;
        x0 = n_xfer;
        fork
            run_pkt({3'd5, 3'd2}, 8);
            begin
                wait (acc_cnt == k);
                for (int c = 0; c < 9; c++) begin
                    @(negedge clk);
                    check("full_en", 32'(out_enable), 1);
                end
                @(negedge clk);
                check("full_rdy", 32'(desc_ready), 1);
            end
        join
        check("full_xfers", 32'(n_xfer - x0), 9);

        // Backpressure: ack low for 4 cycles while the first body flit waits.
        do_reset();
        rand_words(0);
        k = acc_cnt + 1;
        x0 = n_xfer;
        s0 = n_stall;
        fork
            run_pkt({3'd2, 3'd3}, 3);
            begin
                wait (acc_cnt == k);
                @(posedge clk);
                #1;
                ack_level = 1'b0;
                @(negedge clk);
                check("bp_pl_ready", 32'(pl_ready), 0);
                check("bp_en", 32'(out_enable), 1);
                repeat (4) @(posedge clk);
                #1;
                ack_level = 1'b1;
            end
        join
        check("bp_xfers", 32'(n_xfer - x0), 4);
        check("bp_stalls", 32'(n_stall - s0), 4);
`ifdef FLIT_INJECTOR_STATS_EN
        check("bp_stat_stall", stat_stall, 4);
        check("bp_stat_flits", stat_flits, 4);
        check("bp_stat_pkts", stat_pkts, 1);
`endif

        // Payload bubble: two idle payload cycles between words 0 and 1.
        rand_words(0);
        pkt_gaps[1] = 2;
        pat = '{1, 1, 0, 0, 1, 1, 0};
        k = acc_cnt + 1;
        fork
            run_pkt({3'd7, 3'd0}, 3);
            begin
                wait (acc_cnt == k);
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    check("bubble_en", 32'(out_enable), 32'(pat[c]));
                end
            end
        join

        // Illegal lengths 0 and 9: error pulse, no flits, stay idle.
        x0 = n_xfer;
        for (int j = 0; j < 2; j++) begin
            run_pkt(6'($urandom), (j == 0) ? 0 : 9);
            @(negedge clk);
            check("err_clear", 32'(desc_err), 0);
            check("err_state", 32'(dbg_state), 0);
            check("err_en", 32'(out_enable), 0);
            @(posedge clk);
            #1;
        end
        check("illegal_xfers", 32'(n_xfer - x0), 0);

        // Reset mid-packet after two transfers, then a clean len-1 packet.
        rand_words(0);
        dst = {3'd4, 3'd4};
        push_expected(dst, 5);
        pl_valid = 1'b1;
        pl_data = pkt_words[0];
        send_desc(dst, 5);
        @(posedge clk);
        #1;
        pl_data = pkt_words[1];
        @(posedge clk);
        #1;
        rst = 1'b1;
        pl_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_en", 32'(out_enable), 0);
        check("mid_rst_rdy", 32'(desc_ready), 1);
        check("mid_rst_pl_ready", 32'(pl_ready), 0);
        check("mid_rst_state", 32'(dbg_state), 0);
        check("mid_rst_left", 32'(exp_q.size()), 4);
`ifdef FLIT_INJECTOR_STATS_EN
        check("mid_rst_stat_flits", stat_flits, 0);
`endif
        exp_q.delete();
        @(posedge clk);
        #1;
        rand_words(0);
        run_pkt({3'd0, 3'd1}, 1);

        // Randomized packets with random ack, bubbles and illegal lengths.
        ack_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            rand_words(($urandom_range(0, 2) == 0) ? 2 : 0);
            len = $urandom_range(0, 9);
            run_pkt(6'($urandom), len);
        end
        ack_rand = 1'b0;
        check("final_queue", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
